// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative RV32M multiply/divide unit: one result bit per clock behind a start/busy/done handshake.
// Multiply is shift-add on a double-width accumulator; divide is restoring on operand magnitudes.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    logic                   div_signed_in, div_zero_in, div_ovf_in, special_in;
    logic                   neg_a_in, neg_b_in;
    logic [XLEN-1:0]        special_res_in;
    logic signed [W2-1:0]   mcand_in;

    logic [2:0]             op_q;
    logic [4:0]             rd_q;
    logic                   special_q;
    logic [XLEN-1:0]        special_res_q;
    logic signed [W2-1:0]   acc, mcand, acc_nxt;
    logic [XLEN-1:0]        mplier;
    logic                   mul_b_signed;
    logic [XLEN-1:0]        rem, rem_nxt, quot, quot_nxt, dvsr;
    logic [XLEN:0]          rem_sh, diff;
    logic                   neg_q, neg_r;
    logic [CW-1:0]          count;
    logic                   last_iter, accept, early_fin, finish;
    logic [XLEN-1:0]        final_res;

    always_comb begin
        div_signed_in = ~op[0];
        div_zero_in   = (in_2 == '0);
        div_ovf_in    = div_signed_in && (in_1 == MIN_NEG) && (in_2 == '1);
        special_in    = op[2] && (div_zero_in || div_ovf_in);
        if (div_zero_in)
            special_res_in = op[1] ? in_1 : '1;
        else
            special_res_in = op[1] ? '0 : MIN_NEG;
        neg_a_in = div_signed_in && in_1[XLEN-1];
        neg_b_in = div_signed_in && in_2[XLEN-1];
        // MULH and MULHSU treat rs1 as signed; rs2 sign is handled on the last iteration
        if (op == 3'd1 || op == 3'd2)
            mcand_in = {{XLEN{in_1[XLEN-1]}}, in_1};
        else
            mcand_in = {{XLEN{1'b0}}, in_1};
    end

    always_comb begin
        last_iter = (count == CW'(XLEN - 1));
        acc_nxt   = acc;
        // A signed multiplier's top bit weighs -2^(XLEN-1), so it subtracts
        if (mplier[0])
            acc_nxt = (last_iter && mul_b_signed) ? acc - mcand : acc + mcand;
        rem_sh = {rem, quot[XLEN-1]};
        diff   = rem_sh - {1'b0, dvsr};
        if (diff[XLEN]) begin
            rem_nxt  = rem_sh[XLEN-1:0];
            quot_nxt = {quot[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt  = diff[XLEN-1:0];
            quot_nxt = {quot[XLEN-2:0], 1'b1};
        end
        if (special_q)
            final_res = special_res_q;
        else if (!op_q[2])
            final_res = (op_q[1:0] == 2'd0) ? acc_nxt[XLEN-1:0] : acc_nxt[W2-1:XLEN];
        else if (op_q[1])
            final_res = fix_sign(rem_nxt, neg_r);
        else
            final_res = fix_sign(quot_nxt, neg_q);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        early_fin = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept = 1'b1;
                    if (EARLY_OUT && special_in) begin
                        early_fin = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Result and tag change only when an operation completes, so a flush leaves them intact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            if (accept)
                count <= '0;
            else if (state == CALC && !flush)
                count <= count + 1'b1;
            if (early_fin) begin
                result <= special_res_in;
                rd_out <= rd_in;
            end else if (finish) begin
                result <= final_res;
                rd_out <= rd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q          <= op;
            rd_q          <= rd_in;
            special_q     <= special_in;
            special_res_q <= special_res_in;
            acc           <= '0;
            mcand         <= mcand_in;
            mplier        <= in_2;
            mul_b_signed  <= (op == 3'd1);
            rem           <= '0;
            quot          <= neg_a_in ? -in_1 : in_1;
            dvsr          <= neg_b_in ? -in_2 : in_2;
            neg_q         <= neg_a_in ^ neg_b_in;
            neg_r         <= neg_a_in;
        end else if (state == CALC) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quot   <= quot_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Bench for muldiv_unit: 32-bit units with and without early-out, plus an 8-bit unit,
// checked against a wide-integer arithmetic model of the RV32M operations.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] in_1, in_2;
    logic [4:0]  rd_in;
    logic        busy1, done1, busy0, done0;
    logic [31:0] res1, res0;
    logic [4:0]  rd1, rd0;

    logic        start8, flush8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic [4:0]  rdi8, rdo8;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_1(in_1), .in_2(in_2),
        .rd_in(rd_in), .flush(flush), .busy(busy1), .done(done1), .result(res1), .rd_out(rd1));

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_1(in_1), .in_2(in_2),
        .rd_in(rd_in), .flush(flush), .busy(busy0), .done(done0), .result(res0), .rd_out(rd0));

    muldiv_unit #(.XLEN(8), .EARLY_OUT(1'b1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .in_1(a8), .in_2(b8),
        .rd_in(rdi8), .flush(flush8), .busy(busy8), .done(done8), .result(res8), .rd_out(rdo8));

    // Arithmetic model of the RV32M ops at width xl, using 128-bit signed integers
    function automatic logic [31:0] ref_op(input int xl, input logic [2:0] o,
                                           input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] mask, a, b;
        logic signed [127:0] ua, ub, sa, sb, r, lim;
        logic ovf;
        mask = (xl >= 32) ? 32'hFFFF_FFFF : ((32'd1 << xl) - 32'd1);
        a = a_in & mask;
        b = b_in & mask;
        ua = {96'd0, a};
        ub = {96'd0, b};
        lim = 128'sd1 <<< xl;
        sa = a[xl-1] ? ua - lim : ua;
        sb = b[xl-1] ? ub - lim : ub;
        ovf = (sb == -128'sd1) && (sa == -(lim >>> 1));
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> xl;
            3'd2: r = (sa * ub) >>> xl;
            3'd3: r = (ua * ub) >>> xl;
            3'd4: if (b == 0) r = -128'sd1; else if (ovf) r = sa; else r = sa / sb;
            3'd5: if (b == 0) r = -128'sd1; else r = ua / ub;
            3'd6: if (b == 0) r = sa; else if (ovf) r = 128'sd0; else r = sa % sb;
            default: if (b == 0) r = ua; else r = ua % ub;
        endcase
        return r[31:0] & mask;
    endfunction

    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] minv,
                                        input logic [31:0] ones);
        return o[2] && (b == 0 || (!o[0] && a == minv && b == ones));
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd,
                          output logic [31:0] r1, output logic [4:0] t1, output int c1, output int n1,
                          output logic [31:0] r0, output logic [4:0] t0, output int c0, output int n0);
        @(negedge clk);
        op = o; in_1 = a; in_2 = b; rd_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c1 = -1; c0 = -1; n1 = 0; n0 = 0; r1 = '0; r0 = '0; t1 = '0; t0 = '0;
        for (int c = 1; c <= 40; c++) begin
            if (done1 === 1'b1) begin
                n1++;
                if (c1 < 0) begin c1 = c; r1 = res1; t1 = rd1; end
            end
            if (done0 === 1'b1) begin
                n0++;
                if (c0 < 0) begin c0 = c; r0 = res0; t0 = rd0; end
            end
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output int cy);
        @(negedge clk);
        op8 = o; a8 = a; b8 = b; rdi8 = 5'd6; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cy = -1; r = '0;
        for (int c = 1; c <= 12; c++) begin
            if (done8 === 1'b1 && cy < 0) begin cy = c; r = res8; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done1); end
        checks++; if (res1 !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", res1); end
        checks++; if (rd1 !== 5'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd1); end
        checks++; if (busy0 !== 1'b0 || res0 !== 32'd0) begin errors++; $display("FAIL reset_dut0 busy=%b result=%h exp 0/0", busy0, res0); end
        checks++; if (busy8 !== 1'b0 || res8 !== 8'd0 || rdo8 !== 5'd0) begin errors++; $display("FAIL reset_dut8 busy=%b result=%h rd=%h exp 0", busy8, res8, rdo8); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_timing();
        @(negedge clk);
        op = 3'd0; in_1 = 32'd7; in_2 = -32'sd3; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            checks++; if (busy1 !== (c <= 33)) begin errors++; $display("FAIL mul_busy cycle %0d got=%b exp=%b", c, busy1, (c <= 33)); end
            checks++; if (done1 !== (c == 33)) begin errors++; $display("FAIL mul_done cycle %0d got=%b exp=%b", c, done1, (c == 33)); end
            if (c == 33) begin
                checks++; if (res1 !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", res1); end
                checks++; if (rd1 !== 5'd3) begin errors++; $display("FAIL mul_rd got=%h exp=03", rd1); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ov [7];
        logic [31:0] av [7];
        logic [31:0] bv [7];
        logic [31:0] ev [7];
        logic [31:0] r1, r0;
        logic [4:0]  t1, t0;
        int c1, c0, n1, n0;
        ov = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
        av = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        bv = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7};
        ev = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 7; i++) begin
            run_op(ov[i], av[i], bv[i], 5'd17, r1, t1, c1, n1, r0, t0, c0, n0);
            checks++; if (r1 !== ev[i]) begin errors++; $display("FAIL dir_result[%0d] got=%h exp=%h", i, r1, ev[i]); end
            checks++; if (r0 !== ev[i]) begin errors++; $display("FAIL dir_result_noeo[%0d] got=%h exp=%h", i, r0, ev[i]); end
            checks++; if (c1 !== 33 || n1 !== 1) begin errors++; $display("FAIL dir_latency[%0d] cycle=%0d pulses=%0d exp 33/1", i, c1, n1); end
            checks++; if (t1 !== 5'd17 || t0 !== 5'd17) begin errors++; $display("FAIL dir_rd[%0d] got=%0d/%0d exp=17", i, t1, t0); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ov [6];
        logic [31:0] av [6];
        logic [31:0] bv [6];
        logic [31:0] ev [6];
        logic [31:0] r1, r0;
        logic [4:0]  t1, t0;
        int c1, c0, n1, n0;
        ov = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        av = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        bv = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        ev = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        for (int i = 0; i < 6; i++) begin
            run_op(ov[i], av[i], bv[i], 5'd21, r1, t1, c1, n1, r0, t0, c0, n0);
            checks++; if (r1 !== ev[i]) begin errors++; $display("FAIL spc_result[%0d] got=%h exp=%h", i, r1, ev[i]); end
            checks++; if (r0 !== ev[i]) begin errors++; $display("FAIL spc_result_noeo[%0d] got=%h exp=%h", i, r0, ev[i]); end
            checks++; if (c1 !== 1 || n1 !== 1) begin errors++; $display("FAIL spc_early[%0d] cycle=%0d pulses=%0d exp 1/1", i, c1, n1); end
            checks++; if (c0 !== 33 || n0 !== 1) begin errors++; $display("FAIL spc_noeo[%0d] cycle=%0d pulses=%0d exp 33/1", i, c0, n0); end
            checks++; if (t1 !== 5'd21) begin errors++; $display("FAIL spc_rd[%0d] got=%0d exp=21", i, t1); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, e, r1, r0;
        logic [4:0]  t1, t0, tag;
        int c1, c0, n1, n0, ec;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            tag = 5'($urandom_range(0, 31));
            e  = ref_op(32, o, a, b);
            ec = is_special(o, a, b, 32'h8000_0000, 32'hFFFF_FFFF) ? 1 : 33;
            run_op(o, a, b, tag, r1, t1, c1, n1, r0, t0, c0, n0);
            checks++; if (r1 !== e) begin errors++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r1, e); end
            checks++; if (r0 !== e) begin errors++; $display("FAIL rnd_result_noeo[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r0, e); end
            checks++; if (c1 !== ec || c0 !== 33) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d/%0d exp=%0d/33", i, c1, c0, ec); end
            checks++; if (t1 !== tag) begin errors++; $display("FAIL rnd_rd[%0d] got=%0d exp=%0d", i, t1, tag); end
        end
    endtask

    task automatic test_start_ignored();
        int nd;
        nd = 0;
        @(negedge clk);
        op = 3'd0; in_1 = 32'd6; in_2 = 32'd7; rd_in = 5'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin op = 3'd5; in_1 = 32'd100; in_2 = 32'd3; rd_in = 5'd1; start = 1'b1; end
            if (c == 21) start = 1'b0;
            if (done1 === 1'b1) begin
                nd++;
                checks++; if (c !== 33 || res1 !== 32'd42 || rd1 !== 5'd11) begin errors++; $display("FAIL busy_start cycle=%0d result=%h rd=%0d exp 33/0000002a/11", c, res1, rd1); end
            end
            @(negedge clk);
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_pulses got=%0d exp=1", nd); end
    endtask

    task automatic test_flush();
        logic [31:0] r1, r0;
        logic [4:0]  t1, t0;
        int c1, c0, n1, n0, nd;
        run_op(3'd5, 32'd100, 32'd7, 5'd4, r1, t1, c1, n1, r0, t0, c0, n0);
        nd = 0;
        @(negedge clk);
        op = 3'd4; in_1 = -32'sd100; in_2 = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin flush = 1'b1; start = 1'b1; op = 3'd0; in_1 = 32'd3; in_2 = 32'd3; end
            if (c == 11) begin
                checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b/%b exp=0", busy1, busy0); end
                flush = 1'b0; start = 1'b0;
            end
            if (done1 === 1'b1 || done0 === 1'b1) nd++;
            @(negedge clk);
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL flush_done got=%0d pulses exp=0", nd); end
        checks++; if (res1 !== 32'd14 || res0 !== 32'd14) begin errors++; $display("FAIL flush_result got=%h/%h exp=0000000e", res1, res0); end
        checks++; if (rd1 !== 5'd4) begin errors++; $display("FAIL flush_rd got=%0d exp=4", rd1); end
        @(negedge clk);
        op = 3'd0; in_1 = 32'd5; in_2 = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL flush_idle_start got=%b/%b exp=0", busy1, busy0); end
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, first, second;
        n = 0; first = -1; second = -1;
        @(negedge clk);
        op = 3'd0; in_1 = 32'd3; in_2 = 32'd5; rd_in = 5'd2; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 70; c++) begin
            if (c == 68) start = 1'b0;
            if (done1 === 1'b1) begin
                n++;
                if (first < 0) first = c; else if (second < 0) second = c;
                checks++; if (res1 !== 32'd15) begin errors++; $display("FAIL b2b_result cycle %0d got=%h exp=0000000f", c, res1); end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (n !== 2 || first !== 33 || second !== 67) begin errors++; $display("FAIL b2b_timing pulses=%0d at %0d,%0d exp 2 at 33,67", n, first, second); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        op = 3'd0; in_1 = 32'd7; in_2 = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (busy1 !== 1'b1 || res1 !== 32'd15) begin errors++; $display("FAIL arst_pre busy=%b result=%h exp 1/0000000f", busy1, res1); end
        #2 reset = 1'b0;
        #1;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL arst_ctrl busy=%b done=%b exp 0/0", busy1, done1); end
        checks++; if (res1 !== 32'd0 || rd1 !== 5'd0) begin errors++; $display("FAIL arst_data result=%h rd=%0d exp 0/0", res1, rd1); end
        checks++; if (busy0 !== 1'b0 || res0 !== 32'd0) begin errors++; $display("FAIL arst_dut0 busy=%b result=%h exp 0/0", busy0, res0); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL arst_release busy=%b exp=0", busy1); end
    endtask

    task automatic test_xlen8();
        logic [2:0] o;
        logic [7:0] a, b, r, e;
        int cy, ec;
        run8(3'd0, 8'h7F, 8'h7F, r, cy);
        checks++; if (r !== 8'h01 || cy !== 9) begin errors++; $display("FAIL x8_mul got=%h cycle=%0d exp=01 cycle 9", r, cy); end
        run8(3'd3, 8'h7F, 8'h7F, r, cy);
        checks++; if (r !== 8'h3F || cy !== 9) begin errors++; $display("FAIL x8_mulhu got=%h cycle=%0d exp=3f cycle 9", r, cy); end
        checks++; if (rdo8 !== 5'd6) begin errors++; $display("FAIL x8_rd got=%0d exp=6", rdo8); end
        for (int i = 0; i < 14; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 5 == 0) b = 8'd0;
            if (i % 7 == 1) begin a = 8'h80; b = 8'hFF; end
            e  = 8'(ref_op(8, o, {24'd0, a}, {24'd0, b}));
            ec = is_special(o, {24'd0, a}, {24'd0, b}, 32'h80, 32'hFF) ? 1 : 9;
            run8(o, a, b, r, cy);
            checks++; if (r !== e || cy !== ec) begin errors++; $display("FAIL x8_rnd[%0d] op=%0d a=%h b=%h got=%h@%0d exp=%h@%0d", i, o, a, b, r, cy, e, ec); end
        end
    endtask

    initial begin
        start = 1'b0; flush = 1'b0; op = 3'd0; in_1 = '0; in_2 = '0; rd_in = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0; rdi8 = '0;
        test_reset();
        test_mul_timing();
        test_directed();
        test_special();
        test_random();
        test_start_ignored();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_xlen8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
